// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and the command sequencer that feeds it.
//   - OP_* : 4-bit opcode encoding on the ALU's OP_SEL input.
//   - state_t : sequencer FSM states.
//   - MAX_REP : largest legal repeat count; the REP field is 4 bits wide.
package alu_pkg;

  localparam int MAX_REP = 15;

  localparam logic [3:0] OP_ADD  = 4'b0000;  // A + B, carry out
  localparam logic [3:0] OP_SUB  = 4'b0001;  // A - B, carry = borrow
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOTA = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;  // carry = bit shifted out
  localparam logic [3:0] OP_SHR  = 4'b0111;  // carry = bit shifted out
  localparam logic [3:0] OP_INC  = 4'b1000;  // A + 1, carry on wrap
  localparam logic [3:0] OP_DEC  = 4'b1001;  // A - 1, carry = borrow
  localparam logic [3:0] OP_PASA = 4'b1010;
  localparam logic [3:0] OP_PASB = 4'b1011;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_NOR  = 4'b1101;
  localparam logic [3:0] OP_XNOR = 4'b1110;
  localparam logic [3:0] OP_NOP  = 4'b1111;  // illegal as a sequencer command

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ALU_4bit.sv
// Purely combinational 4-bit ALU.
// Ports:
//   A, B     in  4  operands
//   OP_SEL   in  4  opcode (alu_pkg::OP_*)
//   Y        out 4  result (modulo 16)
//   CARRY    out 1  carry / borrow / shifted-out bit; 0 for logic ops
module ALU_4bit
  import alu_pkg::*;
(
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] OP_SEL,
  output logic [3:0] Y,
  output logic       CARRY
);

  always_comb begin
    Y     = 4'h0;
    CARRY = 1'b0;
    case (OP_SEL)
      OP_ADD:  {CARRY, Y} = {1'b0, A} + {1'b0, B};
      OP_SUB:  {CARRY, Y} = {1'b0, A} - {1'b0, B};
      OP_AND:  Y = A & B;
      OP_OR:   Y = A | B;
      OP_XOR:  Y = A ^ B;
      OP_NOTA: Y = ~A;
      OP_SHL:  {CARRY, Y} = {A, 1'b0};
      OP_SHR:  {Y, CARRY} = {1'b0, A};
      OP_INC:  {CARRY, Y} = {1'b0, A} + 5'd1;
      OP_DEC:  {CARRY, Y} = {1'b0, A} - 5'd1;
      OP_PASA: Y = A;
      OP_PASB: Y = B;
      OP_NAND: Y = ~(A & B);
      OP_NOR:  Y = ~(A | B);
      OP_XNOR: Y = ~(A ^ B);
      default: begin
        Y     = 4'h0;
        CARRY = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer upstream of ALU_4bit. Accepts one command per handshake,
// drives registered operands/opcode to the ALU, iterates CMD_REP+1 times with
// ALU_Y fed back as operand A, and holds the final result until consumed.
//
// Handshakes (both sides): a transfer happens on a rising edge where VALID and
// READY are both 1. A producer holds VALID and its payload stable until that
// edge; READY may be asserted before VALID. CMD_READY is 1 only in IDLE, and
// RES_VALID is 1 only in DONE.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   CMD_VALID/READY          command handshake
//   CMD_OP/A/B/USE_ACC/REP   command payload
//   ALU_A/B/OP               registered drive into the ALU
//   ALU_Y, ALU_CARRY         combinational ALU response
//   RES_VALID/READY          result handshake
//   RES_Y/CARRY/CSTICKY/ZERO/ERR  result payload
//   ACC                      accumulator (last legal result)
//   DBG_STATE                current FSM state
module alu_cmd_sequencer
  import alu_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [3:0] CMD_OP,
  input  logic [3:0] CMD_A,
  input  logic [3:0] CMD_B,
  input  logic       CMD_USE_ACC,
  input  logic [3:0] CMD_REP,
  output logic [3:0] ALU_A,
  output logic [3:0] ALU_B,
  output logic [3:0] ALU_OP,
  input  logic [3:0] ALU_Y,
  input  logic       ALU_CARRY,
  output logic       RES_VALID,
  input  logic       RES_READY,
  output logic [3:0] RES_Y,
  output logic       RES_CARRY,
  output logic       RES_CSTICKY,
  output logic       RES_ZERO,
  output logic       RES_ERR,
  output logic [3:0] ACC,
  output state_t     DBG_STATE
);

  state_t     state_q, state_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic [3:0] alu_op_q, alu_op_d;
  logic [3:0] cnt_q, cnt_d;
  logic       csticky_q, csticky_d;
  logic [3:0] res_y_q, res_y_d;
  logic       res_carry_q, res_carry_d;
  logic       res_zero_q, res_zero_d;
  logic       res_err_q, res_err_d;
  logic [3:0] acc_q, acc_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      alu_a_q     <= 4'h0;
      alu_b_q     <= 4'h0;
      alu_op_q    <= OP_NOP;
      cnt_q       <= 4'h0;
      csticky_q   <= 1'b0;
      res_y_q     <= 4'h0;
      res_carry_q <= 1'b0;
      res_zero_q  <= 1'b0;
      res_err_q   <= 1'b0;
      acc_q       <= 4'h0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      cnt_q       <= cnt_d;
      csticky_q   <= csticky_d;
      res_y_q     <= res_y_d;
      res_carry_q <= res_carry_d;
      res_zero_q  <= res_zero_d;
      res_err_q   <= res_err_d;
      acc_q       <= acc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    cnt_d       = cnt_q;
    csticky_d   = csticky_q;
    res_y_d     = res_y_q;
    res_carry_d = res_carry_q;
    res_zero_d  = res_zero_q;
    res_err_d   = res_err_q;
    acc_d       = acc_q;
    case (state_q)
      IDLE: begin
        if (CMD_VALID) begin
          alu_a_d   = CMD_USE_ACC ? acc_q : CMD_A;
          alu_b_d   = CMD_B;
          alu_op_d  = CMD_OP;
          cnt_d     = CMD_REP;
          csticky_d = 1'b0;
          if (CMD_OP == OP_NOP) begin
            // Rejected command: report an error result, leave ACC alone.
            res_y_d     = 4'h0;
            res_carry_d = 1'b0;
            res_zero_d  = 1'b1;
            res_err_d   = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        csticky_d = csticky_q | ALU_CARRY;
        if (cnt_q == 4'h0) begin
          res_y_d     = ALU_Y;
          res_carry_d = ALU_CARRY;
          res_zero_d  = (ALU_Y == 4'h0);
          res_err_d   = 1'b0;
          acc_d       = ALU_Y;
          state_d     = DONE;
        end else begin
          // Feed the result back; B and OP stay fixed for the whole command.
          alu_a_d = ALU_Y;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (RES_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign CMD_READY   = (state_q == IDLE);
  assign RES_VALID   = (state_q == DONE);
  assign ALU_A       = alu_a_q;
  assign ALU_B       = alu_b_q;
  assign ALU_OP      = alu_op_q;
  assign RES_Y       = res_y_q;
  assign RES_CARRY   = res_carry_q;
  assign RES_CSTICKY = csticky_q;
  assign RES_ZERO    = res_zero_q;
  assign RES_ERR     = res_err_q;
  assign ACC         = acc_q;
  assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer connected to ALU_4bit. Driver tasks issue
// directed commands and push hand-computed results into exp_q; a monitor on
// the falling edge pops and compares on every result handshake.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       cmd_valid, cmd_ready, cmd_use_acc;
  logic [3:0] cmd_op, cmd_a, cmd_b, cmd_rep;
  logic [3:0] alu_a, alu_b, alu_op, alu_y;
  logic       alu_carry;
  logic       res_valid, res_ready;
  logic [3:0] res_y;
  logic       res_carry, res_csticky, res_zero, res_err;
  logic [3:0] acc;
  state_t     dbg_state;

  ALU_4bit u_alu (
    .A(alu_a), .B(alu_b), .OP_SEL(alu_op), .Y(alu_y), .CARRY(alu_carry)
  );

  alu_cmd_sequencer u_dut (
    .CLK(clk), .RST(rst),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_OP(cmd_op),
    .CMD_A(cmd_a), .CMD_B(cmd_b), .CMD_USE_ACC(cmd_use_acc), .CMD_REP(cmd_rep),
    .ALU_A(alu_a), .ALU_B(alu_b), .ALU_OP(alu_op),
    .ALU_Y(alu_y), .ALU_CARRY(alu_carry),
    .RES_VALID(res_valid), .RES_READY(res_ready),
    .RES_Y(res_y), .RES_CARRY(res_carry), .RES_CSTICKY(res_csticky),
    .RES_ZERO(res_zero), .RES_ERR(res_err), .ACC(acc), .DBG_STATE(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q[$];
  logic [11:0] mon_act, mon_exp;
  logic [3:0]  a_seen[0:40];
  int          last_lat;

  // Packed result: {acc, err, zero, csticky, carry, y}
  function automatic logic [11:0] mk(input logic [3:0] a, input logic e,
                                     input logic z, input logic cs,
                                     input logic c, input logic [3:0] y);
    return {a, e, z, cs, c, y};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      mon_act = {acc, res_err, res_zero, res_csticky, res_carry, res_y};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL result: unexpected result %0h, nothing expected", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {20'h0, mon_act}, {20'h0, mon_exp});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [3:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic use_acc,
                       input logic [3:0] rep, input logic [11:0] exp,
                       input int exp_lat);
    int n;
    bit seen;
    @(posedge clk); #1;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = use_acc; cmd_rep = rep;
    cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept: CMD_READY stuck at 0");
    end
    exp_q.push_back(exp);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    // Cycle k after the accepting edge is observed at the k-th falling edge.
    seen = 0;
    last_lat = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      a_seen[k] = alu_a;
      if (res_valid) begin
        seen = 1;
        last_lat = k;
      end
    end
    check("latency", last_lat, exp_lat);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: CMD_READY stuck at 0");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [12:0] snap;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_a = 4'h0; cmd_b = 4'h0;
    cmd_use_acc = 1'b0; cmd_rep = 4'h0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res", {res_y, res_carry, res_csticky, res_zero, res_err}, 8'h00);
    check("rst_acc", acc, 0);
    check("rst_alu_ab", {alu_a, alu_b}, 8'h00);
    check("rst_alu_op", alu_op, 4'hF);
    check("rst_state", dbg_state, IDLE);
    @(posedge clk); #1;
    rst = 1'b0;

    // Add 9+8 = 17 -> Y=1, carry
    issue(OP_ADD, 4'd9, 4'd8, 1'b0, 4'd0, mk(4'd1, 0, 0, 1, 1, 4'd1), 2);
    wait_idle();

    // Decrement 3 three times -> 0
    issue(OP_DEC, 4'd3, 4'd0, 1'b0, 4'd2, mk(4'd0, 0, 1, 0, 0, 4'd0), 4);
    check("dec_a_seq", {a_seen[1], a_seen[2], a_seen[3]}, 12'h321);
    wait_idle();

    // Increment ACC (0); CMD_A must be ignored
    issue(OP_INC, 4'd5, 4'd0, 1'b1, 4'd0, mk(4'd1, 0, 0, 0, 0, 4'd1), 2);
    wait_idle();

    // Wrap: E,F,0,1 -> 2; carry seen on F+1 only
    issue(OP_INC, 4'hE, 4'd0, 1'b0, 4'd3, mk(4'd2, 0, 0, 1, 0, 4'd2), 5);
    check("wrap_a_seq", {a_seen[1], a_seen[2], a_seen[3], a_seen[4]}, 16'hEF01);
    wait_idle();

    // Sticky: 8+8 -> 0 c=1; 0+8 -> 8 c=0
    issue(OP_ADD, 4'd8, 4'd8, 1'b0, 4'd1, mk(4'd8, 0, 0, 1, 0, 4'd8), 3);
    check("sticky_alu_b_op", {alu_b, alu_op}, 8'h80);
    wait_idle();

    // Illegal opcode with backpressure; ACC stays 8
    res_ready = 1'b0;
    issue(OP_NOP, 4'd3, 4'd3, 1'b0, 4'd0, mk(4'd8, 1, 1, 0, 0, 4'd0), 1);
    snap = {res_valid, acc, res_err, res_zero, res_csticky, res_carry, res_y};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_res", {res_valid, acc, res_err, res_zero, res_csticky,
                         res_carry, res_y}, snap);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    wait_idle();

    // ACC(8) + 7 = 15
    issue(OP_ADD, 4'd0, 4'd7, 1'b1, 4'd0, mk(4'hF, 0, 0, 0, 0, 4'hF), 2);
    wait_idle();

    // Reset mid-EXEC
    @(posedge clk); #1;
    cmd_op = OP_INC; cmd_a = 4'd0; cmd_b = 4'd0; cmd_use_acc = 1'b0;
    cmd_rep = 4'd10; cmd_valid = 1'b1;
    @(posedge clk); #1;             // accepted at this edge (end of T)
    cmd_valid = 1'b0;
    @(posedge clk); #1;             // T+2
    @(posedge clk); #1;             // T+3
    check("exec_busy", cmd_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;             // T+4
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_acc", acc, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_alu_op", alu_op, 4'hF);
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_csticky", res_csticky, 0);

    // Normal operation after reset
    issue(OP_ADD, 4'd9, 4'd8, 1'b0, 4'd0, mk(4'd1, 0, 0, 1, 1, 4'd1), 2);
    wait_idle();
    repeat (2) @(negedge clk);

    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
